// File: rtl/mem_access_unit_if.sv
// ============================================================================
// mem_access_unit_if -- pipeline request/response and data-memory bus bundle
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;

  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        resp_err;
  logic        store_err;

  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        mem_MemWrite;
  logic        mem_MemRead;
  logic        mem_distinct;

  // slave: the access unit itself
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_rd,
    output req_ready,
    output resp_valid, resp_data, resp_rd, resp_err, store_err,
    input  resp_ready,
    output mem_address, mem_write_data, mem_MemWrite, mem_MemRead, mem_distinct,
    input  mem_read_data
  );

  // master: pipeline and data memory seen together
  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_rd,
    input  req_ready,
    input  resp_valid, resp_data, resp_rd, resp_err, store_err,
    output resp_ready,
    input  mem_address, mem_write_data, mem_MemWrite, mem_MemRead, mem_distinct,
    output mem_read_data
  );
endinterface

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// mem_access_unit -- single-outstanding load/store sequencer with range check
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module mem_access_unit #(
  parameter int ADDR_BITS = 19
) (
  input  logic              CLK,
  input  logic              reset,
  mem_access_unit_if.slave  bus
);

  localparam logic [31:0] ADDR_MASK = (32'h1 << ADDR_BITS) - 32'h1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD   = 3'd2,
    CAP  = 3'd3,
    RESP = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic [31:0] mem_write_data_q, mem_write_data_d;
  logic        mem_write_q, mem_write_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_distinct_q, mem_distinct_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic [4:0]  resp_rd_q, resp_rd_d;
  logic        resp_err_q, resp_err_d;
  logic        store_err_q, store_err_d;
  logic [4:0]  rd_tag_q, rd_tag_d;
  logic        in_range;

  always_comb begin
    state_d          = state_q;
    mem_address_d    = mem_address_q;
    mem_write_data_d = mem_write_data_q;
    mem_write_d      = mem_write_q;
    mem_read_d       = mem_read_q;
    mem_distinct_d   = mem_distinct_q;
    resp_valid_d     = resp_valid_q;
    resp_data_d      = resp_data_q;
    resp_rd_d        = resp_rd_q;
    resp_err_d       = resp_err_q;
    store_err_d      = 1'b0;
    rd_tag_d         = rd_tag_q;
    in_range         = (bus.req_addr & ~ADDR_MASK) == 32'h0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (bus.req_write) begin
            if (in_range) begin
              state_d          = WR;
              mem_write_d      = 1'b1;
              mem_distinct_d   = 1'b1;
              mem_address_d    = bus.req_addr & ADDR_MASK;
              mem_write_data_d = bus.req_wdata;
            end else begin
              store_err_d = 1'b1;
            end
          end else begin
            rd_tag_d = bus.req_rd;
            if (in_range) begin
              state_d       = RD;
              mem_read_d    = 1'b1;
              mem_address_d = bus.req_addr & ADDR_MASK;
            end else begin
              // Out-of-range loads skip memory and answer with an error at once
              state_d      = RESP;
              resp_valid_d = 1'b1;
              resp_data_d  = 32'h0;
              resp_rd_d    = bus.req_rd;
              resp_err_d   = 1'b1;
            end
          end
        end
      end
      WR: begin
        state_d        = IDLE;
        mem_write_d    = 1'b0;
        mem_distinct_d = 1'b0;
      end
      RD: begin
        state_d    = CAP;
        mem_read_d = 1'b0;
      end
      CAP: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_data_d  = bus.mem_read_data;
        resp_rd_d    = rd_tag_q;
        resp_err_d   = 1'b0;
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q          <= IDLE;
      mem_address_q    <= 32'h0;
      mem_write_data_q <= 32'h0;
      mem_write_q      <= 1'b0;
      mem_read_q       <= 1'b0;
      mem_distinct_q   <= 1'b0;
      resp_valid_q     <= 1'b0;
      resp_data_q      <= 32'h0;
      resp_rd_q        <= 5'h0;
      resp_err_q       <= 1'b0;
      store_err_q      <= 1'b0;
      rd_tag_q         <= 5'h0;
    end else begin
      state_q          <= state_d;
      mem_address_q    <= mem_address_d;
      mem_write_data_q <= mem_write_data_d;
      mem_write_q      <= mem_write_d;
      mem_read_q       <= mem_read_d;
      mem_distinct_q   <= mem_distinct_d;
      resp_valid_q     <= resp_valid_d;
      resp_data_q      <= resp_data_d;
      resp_rd_q        <= resp_rd_d;
      resp_err_q       <= resp_err_d;
      store_err_q      <= store_err_d;
      rd_tag_q         <= rd_tag_d;
    end
  end

  assign bus.req_ready      = (state_q == IDLE);
  assign bus.resp_valid     = resp_valid_q;
  assign bus.resp_data      = resp_data_q;
  assign bus.resp_rd        = resp_rd_q;
  assign bus.resp_err       = resp_err_q;
  assign bus.store_err      = store_err_q;
  assign bus.mem_address    = mem_address_q;
  assign bus.mem_write_data = mem_write_data_q;
  assign bus.mem_MemWrite   = mem_write_q;
  assign bus.mem_MemRead    = mem_read_q;
  assign bus.mem_distinct   = mem_distinct_q;

endmodule

`default_nettype wire

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have parameter ADDR_BITS, default 19, giving the number of low address bits passed to data memory.
REQ-002 CLK  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  reset, asynchronous and active-low; asserted (0) clears all state immediately.
REQ-004 req_valid  input  1  pipeline presents a load/store request.
REQ-005 req_ready  output  1  block accepts a request this cycle.
REQ-006 req_write  input  1  1 = store, 0 = load.
REQ-007 req_addr  input  32  byte/word address from ALU.
REQ-008 req_wdata  input  32  store data.
REQ-009 req_rd  input  5  destination register tag of a load.
REQ-010 resp_valid  output  1  load result available.
REQ-011 resp_ready  input  1  writeback consumes the result.
REQ-012 resp_data  output  32  load result.
REQ-013 resp_rd  output  5  tag of the returned load.
REQ-014 resp_err  output  1  returned load was out of range.
REQ-015 store_err  output  1  one-cycle pulse: store dropped as out of range.
REQ-016 mem_address  output  32  to data memory address; bits [31:ADDR_BITS] SHALL be 0.
REQ-017 mem_write_data  output  32  to data memory write_data.
REQ-018 mem_MemWrite, mem_MemRead, mem_distinct  output  1 each  to data memory MemWrite, MemRead, distinct.
REQ-019 mem_read_data  input  32  from data memory read_data; valid one cycle after the clock edge that samples mem_MemRead=1.

Function
REQ-020 States SHALL be IDLE, WR, RD, CAP, RESP; all mem_* and resp_* outputs SHALL be registered.
REQ-021 req_ready SHALL be 1 only in IDLE; a request is accepted on an edge with req_valid=1 and req_ready=1.
REQ-022 Range check: request is in range iff req_addr[31:ADDR_BITS]==0.
REQ-023 Accepted in-range store: IDLE->WR; in WR, mem_MemWrite=1, mem_distinct=1, mem_MemRead=0, address/data latched from the request; WR->IDLE after exactly one cycle.
REQ-024 mem_distinct SHALL be 1 only in WR, so each accepted store produces exactly one write cycle.
REQ-025 Accepted out-of-range store: stays IDLE, no memory enable asserted, store_err=1 for the following cycle only.
REQ-026 Accepted in-range load: IDLE->RD (mem_MemRead=1, mem_MemWrite=0, mem_distinct=0) ->CAP (enables 0; mem_read_data sampled into resp_data at end of CAP) ->RESP.
REQ-027 Accepted out-of-range load: IDLE->RESP directly, with resp_data=0 and resp_err=1.
REQ-028 In RESP: resp_valid=1, with resp_data/resp_rd/resp_err held stable until an edge with resp_ready=1, then ->IDLE.
REQ-029 Latency: in-range load resp_valid SHALL rise 3 edges after the accepting edge; out-of-range load 1 edge after.
REQ-030 Throughput: at most one store per 2 cycles; at most one load per 4 cycles with resp_ready held 1.
REQ-031 mem_MemRead and mem_MemWrite SHALL never both be 1; both SHALL be 0 in IDLE, CAP and RESP.
REQ-032 resp_rd SHALL equal the req_rd latched at acceptance; resp_err SHALL be 0 for in-range loads.
REQ-033 req_* inputs SHALL be ignored outside the accepting edge; changes during WR/RD/CAP/RESP SHALL have no effect.

Reset
REQ-034 While reset=0: state=IDLE; req_ready=1 on release; resp_valid=0, resp_data=0, resp_rd=0, resp_err=0, store_err=0; mem_address=0, mem_write_data=0, mem_MemWrite=0, mem_MemRead=0, mem_distinct=0.
REQ-035 Reset asserted in WR SHALL drop mem_MemWrite/mem_distinct immediately (asynchronously); the store is aborted, not retried.
REQ-036 Reset asserted in RD/CAP/RESP SHALL discard the pending load; no resp_valid after release until a new load.

Verification
REQ-037 Store addr 0x40, data 0xDEADBEEF -> exactly one cycle with MemWrite=1, distinct=1, mem_address=0x40; req_ready low that cycle.
REQ-038 Load addr 0x40 after REQ-037 store, req_rd=5, resp_ready=1 -> resp_valid 3 edges after accept, resp_data=0xDEADBEEF, resp_rd=5, resp_err=0.
REQ-039 Load with resp_ready=0 for 4 cycles -> resp_valid and resp_data stable for all 4; req_ready=0; clears one edge after resp_ready=1.
REQ-040 Store addr 0x0008_0000 (ADDR_BITS=19) -> no MemWrite, store_err pulse 1 cycle; load there -> resp_valid next cycle, resp_data=0, resp_err=1.
REQ-041 reset=0 mid-WR -> MemWrite falls before the next edge; subsequent load of that address returns the prior contents.
REQ-042 Back-to-back store/load stream with req_valid held 1 -> MemRead and MemWrite never high together; one distinct pulse per store.
